// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// The master modport is the initiator side, slave is the memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port word memory answering one load/store at a time after LATENCY wait cycles.
// Define DMEM_ALIGN_CHECK_EN to fault (rsp_err) requests whose addr[1:0] is non-zero.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    mis_q, mis_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [31:0]             mem_q [DEPTH];

  logic                    accept;
  logic                    enter_resp;
  logic                    req_mis;
  logic                    op_we;
  logic                    op_err;
  logic [DEPTH_LOG2-1:0]   op_idx;
  logic [31:0]             op_wdata;
  logic                    mem_we;
  logic                    unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = |bus.req_addr[1:0];
`else
  assign req_mis = 1'b0;
`endif

  assign unused_addr_bits = ^bus.req_addr;

  assign bus.req_ready = (state_q == IDLE) && rst;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;

  // With LATENCY = 0 RESP is entered on the accepting edge, so the live request is the operand.
  assign op_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign op_err   = (state_q == IDLE) ? req_mis       : mis_q;
  assign op_idx   = (state_q == IDLE) ? bus.req_addr[DEPTH_LOG2+1:2] : idx_q;
  assign op_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    mis_d      = mis_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          mis_d   = req_mis;
          idx_d   = bus.req_addr[DEPTH_LOG2+1:2];
          wdata_d = bus.req_wdata;
          if (LAT == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = (!op_we && !op_err) ? mem_q[op_idx] : 32'd0;
    end
  end

  assign mem_we = enter_resp && op_we && !op_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[op_idx] <= op_wdata;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=0 responder driven by table vectors and
// hand-written sequences, with expected responses queued at request time.
module tb_dmem_responder;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk;
  logic rst;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT_A)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT_B)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", name, act, req);
    end
  endtask

  function automatic logic f_req_ready(input int sel);
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction
  function automatic logic f_rsp_valid(input int sel);
    return (sel == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
  endfunction
  function automatic logic [31:0] f_rsp_rdata(input int sel);
    return (sel == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
  endfunction
  function automatic logic f_rsp_err(input int sel);
    return (sel == 0) ? bus_a.rsp_err : bus_b.rsp_err;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
    end else begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
    end
  endtask

  task automatic set_rsp_ready(input int sel, input logic v);
    if (sel == 0) bus_a.rsp_ready = v;
    else          bus_b.rsp_ready = v;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic transact(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
    exp_t e;
    exp_t got;
    int   cyc;
    int   lat;
    logic [31:0] junk;
    lat = (sel == 0) ? LAT_A : LAT_B;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    check("req_ready_before_accept", 32'(f_req_ready(sel)), 32'd1);
    set_req(sel, 1'b1, we, addr, wdata);
    @(posedge clk);
    #1;
    junk = $urandom();
    set_req(sel, 1'b0, ~we, junk, ~wdata);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!f_rsp_valid(sel) && cyc < 40);
    got = sb_q.pop_front();
    if (!f_rsp_valid(sel)) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: dut%0d no rsp_valid after %0d cycles, wanted %0d", sel, cyc, lat + 1);
      return;
    end
    check("rsp_latency", 32'(cyc), 32'(lat + 1));
    check("rsp_rdata", f_rsp_rdata(sel), got.rdata);
    check("rsp_err", 32'(f_rsp_err(sel)), 32'(got.err));
    $display("txn dut%0d %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d", sel,
             we ? "ST" : "LD", addr, wdata, f_rsp_rdata(sel), f_rsp_err(sel), cyc);
    for (int h = 0; h < hold; h++) begin
      check("hold_rsp_valid", 32'(f_rsp_valid(sel)), 32'd1);
      check("hold_rsp_rdata", f_rsp_rdata(sel), got.rdata);
      check("hold_req_ready", 32'(f_req_ready(sel)), 32'd0);
      @(negedge clk);
    end
    set_rsp_ready(sel, 1'b1);
    @(posedge clk);
    #1;
    set_rsp_ready(sel, 1'b0);
    check("rsp_valid_after_hs", 32'(f_rsp_valid(sel)), 32'd0);
    check("req_ready_in_hs_cycle", 32'(f_req_ready(sel)), 32'd1);
    @(negedge clk);
  endtask

  vec_t vecs[8];
  logic [31:0] model [256];

  initial begin
    logic [31:0] r;
    int          idx;
    logic [31:0] mis_rd;
    logic        mis_err;
    logic [31:0] w20_after;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    bus_a.rsp_ready = 1'b0;
    bus_b.rsp_ready = 1'b0;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0410, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h0000_0001,  32'h0,         1'b0};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,          32'h0000_0001, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_03FC, 32'hA5A5_0001,  32'h0,         1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          32'hA5A5_0001, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0044, 32'h0000_0055,  32'h0,         1'b0};
    vecs[7] = '{1'b0, 32'h1234_5444, 32'h0,          32'h0000_0055, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
    check("rst_req_ready_b", 32'(bus_b.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    transact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      transact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 0);
    end

    transact(0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 5);

    transact(1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'd0, 1'b0, 0);
    transact(1, 1'b0, 32'h0000_0000, 32'd0, 32'h1234_5678, 1'b0, 0);

    // Reset during WAIT of a store must leave word 0x20 untouched.
    set_req(0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus_a.req_ready), 32'd0);
    check("midrst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("midrst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
    $display("txn dut0 RST during WAIT of ST addr=00000020 wdata=cafef00d");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("req_ready_after_rst", 32'(bus_a.req_ready), 32'd1);
    @(negedge clk);
    transact(0, 1'b0, 32'h0000_0020, 32'd0, 32'h0000_0001, 1'b0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
    mis_rd    = 32'd0;
    mis_err   = 1'b1;
    w20_after = 32'h0000_0001;
`else
    mis_rd    = 32'hBAD0_BAD0;
    mis_err   = 1'b0;
    w20_after = 32'hBAD0_BAD0;
`endif
    transact(0, 1'b1, 32'h0000_0022, 32'hBAD0_BAD0, 32'd0, mis_err, 0);
    transact(0, 1'b0, 32'h0000_0020, 32'd0, w20_after, 1'b0, 0);
    transact(0, 1'b0, 32'h0000_0023, 32'd0, mis_rd, mis_err, 0);

    for (int k = 0; k < 6; k++) begin
      idx = 128 + int'($urandom_range(0, 127));
      r = $urandom();
      model[idx] = r;
      transact(0, 1'b1, (r & 32'hFFFF_FC00) | 32'(idx << 2), r, 32'd0, 1'b0, 0);
      r = $urandom();
      transact(0, 1'b0, (r & 32'hFFFF_FC00) | 32'(idx << 2), 32'd0, model[idx], 1'b0, k % 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of memory depth in 32-bit words (256 words).
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts response.
REQ-012 rsp_rdata  output  32  load data; 0 for store responses.
REQ-013 rsp_err  output  1  request faulted (see Configuration).

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE with rst deasserted; request accepted on the edge where req_valid and req_ready are both 1.
REQ-016 On acceptance the block SHALL register req_we, req_addr and req_wdata, load the wait counter with LATENCY, and go to WAIT, or directly to RESP if LATENCY = 0.
REQ-017 In WAIT the counter SHALL decrement once per cycle; at 1 -> RESP on the next edge.
REQ-018 rsp_valid SHALL rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-019 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits ignored (addresses alias, wrap modulo 4*2^DEPTH_LOG2 bytes).
REQ-020 A store SHALL commit to memory on the edge entering RESP; no earlier.
REQ-021 A load SHALL sample memory on the edge entering RESP, returning data including every previously committed store.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is 1; that edge -> IDLE with rsp_valid 0.
REQ-023 req_ready SHALL rise one cycle after the response handshake (no same-cycle accept of the next request).
REQ-024 req_valid while req_ready = 0 SHALL be ignored with no state change.
REQ-025 Request inputs SHALL be don't-care outside the accepting edge.

Reset
REQ-026 While rst = 0: state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-027 req_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-028 Reset mid-operation SHALL drop the pending request; an uncommitted store SHALL NOT reach memory.
REQ-029 Memory contents SHALL NOT be reset and SHALL persist across reset.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN selects alignment checking.
REQ-031 Defined: request with addr[1:0] != 0 SHALL respond with rsp_err = 1 and rsp_rdata = 0 after normal latency, store suppressed.
REQ-032 Undefined: addr[1:0] ignored, rsp_err tied to 0, all requests execute.

Verification
REQ-033 Reset release, LATENCY=2: store 0xDEADBEEF at 0x10 -> rsp_valid rises 3 cycles after accept, rsp_rdata 0, rsp_err 0.
REQ-034 Load 0x10 after REQ-033 -> rsp_rdata 0xDEADBEEF; load 0x410 (aliases, DEPTH_LOG2=8) -> 0xDEADBEEF.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0 throughout; req_ready 1 one cycle after handshake.
REQ-036 LATENCY=0: store 0x12345678 at 0x0 -> rsp_valid next cycle; back-to-back load 0x0 -> 0x12345678.
REQ-037 Assert rst during WAIT of store 0xCAFEF00D at 0x20 (prior value 0x1) -> outputs zeroed, later load 0x20 returns 0x1.
REQ-038 DMEM_ALIGN_CHECK_EN defined: store to 0x22 -> rsp_err 1, load 0x20 unchanged; undefined: same store writes word 0x20, rsp_err 0.
